inst_cache_responder: RTL



---
 rtl/inst_cache_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/inst_cache_responder.sv
// Instruction-side responder: direct-mapped, one-word-per-line I-cache that
// serves fetcher PC requests and fills missing lines byte-by-byte over the
// shared memory bus through an arbiter request/grant handshake. Read-only.
module inst_cache_responder #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  _clear,
    input  logic                  _pc_valid,
    input  logic [ADDR_WIDTH-1:0] _pc,
    output logic                  _inst_ready_in,
    output logic [31:0]           _inst_in,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_a,
    input  logic [7:0]            mem_din
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_t;

    state_t state_q, state_d;

    // Line storage; only the valid bits need a reset value
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [LINES-1:0]      valid_q;

    // Latched request (tag and index fields of req_pc)
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic [INDEX_BITS-1:0] req_idx_q, req_idx_d;

    // Fill bookkeeping
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [1:0]            recv_cnt_q, recv_cnt_d;
    logic                  byte_pend_q, byte_pend_d;
    logic [23:0]           buf_q, buf_d;

    // Registered outputs
    logic                  ready_q, ready_d;
    logic [31:0]           inst_q, inst_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;

    logic                  fill_we;
    logic [31:0]           fill_word;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic                  hit;

    assign pc_idx    = _pc[INDEX_BITS+1:2];
    assign pc_tag    = _pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit       = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    // The 4th byte arrives straight off the bus and completes the word
    assign fill_word = {mem_din, buf_q};

    assign _inst_ready_in = ready_q;
    assign _inst_in       = inst_q;
    assign mem_req        = mem_req_q;
    assign mem_a          = mem_a_q;

    // State register: async reset, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush overrides everything and drops back to IDLE
    always_comb begin
        state_d = state_q;
        if (_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (_pc_valid) state_d = hit ? RESP : FILL;
                FILL:    if (byte_pend_q && recv_cnt_q == 2'd3) state_d = RESP;
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output / datapath next values: lookup, byte issue and capture, word assembly
    always_comb begin
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        byte_pend_d = 1'b0;
        buf_d       = buf_q;
        ready_d     = 1'b0;
        inst_d      = inst_q;
        mem_req_d   = mem_req_q;
        mem_a_d     = mem_a_q;
        fill_we     = 1'b0;

        if (_clear) begin
            // Abandon any fill; clearing the pending flag drops the in-flight byte
            mem_req_d   = 1'b0;
            byte_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (_pc_valid) begin
                        req_tag_d = pc_tag;
                        req_idx_d = pc_idx;
                        if (hit) begin
                            inst_d  = data_mem[pc_idx];
                            ready_d = 1'b1;
                        end else begin
                            mem_req_d   = 1'b1;
                            mem_a_d     = _pc;
                            issue_cnt_d = '0;
                            recv_cnt_d  = '0;
                        end
                    end
                end
                FILL: begin
                    if (mem_req_q && mem_gnt) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        mem_a_d     = mem_a_q + ADDR_WIDTH'(1);
                        byte_pend_d = 1'b1;
                        if (issue_cnt_q == 3'd3) begin
                            mem_req_d = 1'b0;
                        end
                    end
                    if (byte_pend_q) begin
                        recv_cnt_d = recv_cnt_q + 2'd1;
                        case (recv_cnt_q)
                            2'd0: buf_d[7:0]   = mem_din;
                            2'd1: buf_d[15:8]  = mem_din;
                            2'd2: buf_d[23:16] = mem_din;
                            default: begin
                                inst_d  = fill_word;
                                ready_d = 1'b1;
                                fill_we = 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers, plus the valid bits
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q     <= '0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            byte_pend_q <= 1'b0;
            buf_q       <= '0;
            ready_q     <= 1'b0;
            inst_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_a_q     <= '0;
        end else if (rdy_in) begin
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            byte_pend_q <= byte_pend_d;
            buf_q       <= buf_d;
            ready_q     <= ready_d;
            inst_q      <= inst_d;
            mem_req_q   <= mem_req_d;
            mem_a_q     <= mem_a_d;
            if (fill_we) begin
                valid_q[req_idx_q] <= 1'b1;
            end
        end
    end

    // Tag/data array write on completion of a fill
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            tag_mem[req_idx_q]  <= req_tag_q;
            data_mem[req_idx_q] <= fill_word;
        end
    end

endmodule
